// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-item vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VEND      = 2'd1,
    CHG_PULSE = 2'd2,
    CHG_GAP   = 2'd3
  } state_t;

  localparam int unsigned MAX_ITEMS = 8;
  localparam int unsigned NICKEL    = 5;
  localparam int unsigned DIME      = 10;
  localparam int unsigned QUARTER   = 25;

  // One-hot of the lowest set bit of req (zero when nothing is requestable).
  function automatic logic [MAX_ITEMS-1:0] lowest_avail(input logic [MAX_ITEMS-1:0] req);
    return req & (~req + MAX_ITEMS'(1));
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Coin/button front-end and dispenser-side signals of the vending controller.
interface vend_ctrl_multi_if #(
  parameter int NUM_ITEMS = 2,
  parameter int CREDIT_W  = 7
) ();
  logic                 ni;
  logic                 di;
  logic                 qu;
  logic [NUM_ITEMS-1:0] sel;
  logic                 cancel;
  logic [NUM_ITEMS-1:0] sold_out;
  logic [NUM_ITEMS-1:0] give;
  logic                 change;
  logic                 coin_reject;
  logic [CREDIT_W-1:0]  credit;
  logic                 busy;

  modport master (
    output ni, di, qu, sel, cancel, sold_out,
    input  give, change, coin_reject, credit, busy
  );

  modport slave (
    input  ni, di, qu, sel, cancel, sold_out,
    output give, change, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_change_ctrl.sv
// Change payout sequencer: alternates one-cycle nickel pulses and gaps until credit is exhausted.
module vend_change_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  output logic                dec,
  output logic                change,
  output logic                done
);

  state_t phase, phase_nxt;

  always_ff @(posedge CLK) begin
    if (!rst) begin
      phase  <= IDLE;
      change <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      change <= dec;
    end
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      CHG_PULSE: phase_nxt = CHG_GAP;
      CHG_GAP:   phase_nxt = (credit != '0) ? CHG_PULSE : IDLE;
      default:   phase_nxt = start ? CHG_PULSE : IDLE;
    endcase
  end

  // A nickel leaves the credit register on every entry to the pulse phase.
  always_comb begin
    dec  = (phase_nxt == CHG_PULSE);
    done = (phase == CHG_GAP) && (credit == '0);
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Parametrised vending controller: coin credit, lowest-index item vend, nickel change/refund.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 2,
  parameter int PRICE     = 45,
  parameter int CREDIT_W  = 7
) (
  input  logic             CLK,
  input  logic             rst,
  vend_ctrl_multi_if.slave bus
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t                 state, state_nxt;
  logic [CREDIT_W-1:0]    credit_q, credit_nxt, coin_val;
  logic [NUM_ITEMS-1:0]   give_q, give_nxt;
  logic                   reject_q, reject_nxt, busy_q;
  logic [MAX_ITEMS-1:0]   pick;
  logic                   coin_any, coin_accept, refund, can_buy;
  logic                   start, dec, done;

  assign pick     = lowest_avail(MAX_ITEMS'(bus.sel & ~bus.sold_out));
  assign coin_any = bus.ni | bus.di | bus.qu;
  assign refund   = (state == IDLE) && bus.cancel && (credit_q != '0);
  assign can_buy  = (state == IDLE) && !refund && (|pick) && (credit_q >= PRICE_C);
  // Button events win over a same-cycle coin, which is then bounced.
  assign coin_accept = coin_any && (state == IDLE) && !refund && !can_buy && (credit_q < PRICE_C);

  always_comb begin
    if (bus.qu)      coin_val = CREDIT_W'(QUARTER);
    else if (bus.di) coin_val = CREDIT_W'(DIME);
    else             coin_val = CREDIT_W'(NICKEL);
  end

  vend_change_ctrl #(.CREDIT_W(CREDIT_W)) u_change (
    .CLK    (CLK),
    .rst    (rst),
    .start  (start),
    .credit (credit_q),
    .dec    (dec),
    .change (bus.change),
    .done   (done)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state    <= IDLE;
      credit_q <= '0;
      give_q   <= '0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit_q <= credit_nxt;
      give_q   <= give_nxt;
      reject_q <= reject_nxt;
      busy_q   <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (refund) begin
          state_nxt = CHG_PULSE;
          start     = 1'b1;
        end else if (can_buy) begin
          state_nxt = VEND;
        end
      end
      VEND: begin
        if (credit_q != '0) begin
          state_nxt = CHG_PULSE;
          start     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      CHG_PULSE: state_nxt = CHG_GAP;
      CHG_GAP:   state_nxt = done ? IDLE : CHG_PULSE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    credit_nxt = credit_q;
    give_nxt   = '0;
    reject_nxt = coin_any && !coin_accept;
    if (can_buy) begin
      credit_nxt = credit_q - PRICE_C;
      give_nxt   = pick[NUM_ITEMS-1:0];
    end else if (dec) begin
      credit_nxt = credit_q - CREDIT_W'(NICKEL);
    end else if (coin_accept) begin
      credit_nxt = credit_q + coin_val;
    end
  end

  assign bus.give        = give_q;
  assign bus.coin_reject = reject_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised vending controller. Accepts nickel/dime/quarter pulses into a credit register and vends one of `NUM_ITEMS` products at a configurable price. It honours per-item sold-out flags and a cancel/refund request, and pays change as a train of nickel pulses. It sits between the coin/button debounce front end and the dispenser drivers.

## Interface
Parameters:
- `NUM_ITEMS`, 2: number of product channels (1..8).
- `PRICE`, 45: item price in cents. Must be a multiple of 5 and ≥ 5.
- `CREDIT_W`, 7: credit register width. Must satisfy `CREDIT_W ≥ clog2(PRICE+21)`.

Ports:
- `CLK` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-low reset. It is sampled on the `CLK` rising edge.
- `ni` in 1: nickel inserted, one-cycle pulse.
- `di` in 1: dime inserted, one-cycle pulse.
- `qu` in 1: quarter inserted, one-cycle pulse.
- `sel` in `NUM_ITEMS`: product request, one bit per item, pulse.
- `cancel` in 1: refund request, pulse.
- `sold_out` in `NUM_ITEMS`: level, item i is empty.
- `give` out `NUM_ITEMS`: one-cycle dispense pulse for item i.
- `change` out 1: one-cycle pulse meaning "eject one nickel".
- `coin_reject` out 1: one-cycle pulse; the coin sampled last cycle was not credited.
- `credit` out `CREDIT_W`: current credit in cents.
- `busy` out 1: high in VEND, CHG_PULSE and CHG_GAP.

## Operation
Reset values: all outputs are 0, `credit` is 0, and the state is IDLE.

**Coin priority.** When several coins arrive in the same cycle, only the highest-value coin is considered: `qu` > `di` > `ni`.

**States and transitions.**
- **IDLE / CREDIT** (a single state; `credit` may be non-zero).
  - Coin arriving while `credit < PRICE`: add 5, 10 or 25 to `credit`.
  - Coin arriving while `credit ≥ PRICE`: not credited; pulse `coin_reject`.
  - Maximum reachable credit is therefore `PRICE+20`.
  - `cancel` with `credit > 0`: go to CHG_PULSE. Nothing is vended.
  - `cancel` with `credit == 0`: ignored.
  - `sel` with `credit ≥ PRICE`: choose the lowest index i for which `sel[i]=1` and `sold_out[i]=0`.
    - Go to VEND.
    - Assert `give[i]` during VEND.
    - Set `credit ← credit − PRICE`.
  - `sel` with insufficient credit, or with only sold-out items requested: ignored; state unchanged.
  - Simultaneous events:
    - `cancel` beats `sel`.
    - `sel`/`cancel` beat a same-cycle coin; that coin is rejected.
- **VEND**: `give[i]=1` for exactly one cycle.
  - `credit > 0`: go to CHG_PULSE.
  - `credit == 0`: go to IDLE.
- **CHG_PULSE**: `change=1` for one cycle. On entry, `credit ← credit − 5`. Next state is CHG_GAP.
- **CHG_GAP**: `change=0`.
  - `credit > 0`: go to CHG_PULSE.
  - `credit == 0`: go to IDLE.

**Inputs while `busy`.** Coins in VEND, CHG_PULSE or CHG_GAP are rejected with `coin_reject`. `sel` and `cancel` are ignored.

**Arithmetic.** All arithmetic is unsigned in cents. `credit` never underflows, because it is always a multiple of 5 and only decremented when > 0.

**Reset mid-operation.** Credit and any remaining change are discarded. Outputs are 0 after the reset edge.

## Timing
- Coin sampled at edge k: `credit` is updated after edge k. `coin_reject` is high during cycle k+1.
- `sel` accepted at edge k:
  - `give` is high during cycle k+1.
  - The first `change` pulse is high during cycle k+2.
  - Further pulses follow every 2 cycles.
- Refund or change of n nickels:
  - `change` is high in cycles k+2, k+4, …, k+2n (for a refund, starting one cycle earlier at k+1).
  - IDLE is reached one cycle after the last GAP.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Package `vend_pkg` holds:
  - state enum `{IDLE, VEND, CHG_PULSE, CHG_GAP}`;
  - coin constants `NICKEL=5`, `DIME=10`, `QUARTER=25`;
  - a function that returns the lowest-index available selection.
- One sub-module is natural: `vend_change_ctrl`. It owns the CHG_PULSE/CHG_GAP sequencing and the credit decrement, and its interface is a start strobe plus a done flag.

## Test plan
- PRICE=45. `qu`, `di`, `di` → `credit` 25, 35, 45. Then `sel=2'b10` → `give[1]` for one cycle, no `change`, `credit`=0, back to IDLE.
- `qu`, `di`, `qu` → `credit` 60. `sel[0]` → `give[0]`, then exactly 3 `change` pulses spaced 2 cycles apart, `credit` 15→0.
- `di`, `di`, `ni` → `credit` 25. `cancel` → 5 `change` pulses, no `give`, `credit` 0.
- `credit`=45, then insert `qu` → `coin_reject` pulse, `credit` stays 45. `sel=2'b11` with `sold_out=2'b01` → `give[1]` only. `sel=2'b01` alone with `sold_out[0]=1` → no response.
- Same-cycle `cancel` and `sel[0]` at credit 50 → 10 `change` pulses, `give` stays 0.
- `rst=0` during the second `change` pulse of a 4-pulse payout → after that edge `change`=0, `credit`=0, `busy`=0, and no further pulses.
